// File: rtl/jogo_memoria_pkg.sv
// Shared definitions for the memory game: state encoding, LFSR taps and
// the substitute used when the player seed is all zeros.
package jogo_memoria_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    MOSTRA_LED     = 4'd2,
    MOSTRA_APAGADO = 4'd3,
    ESPERA         = 4'd4,
    COMPARA        = 4'd5,
    PROXIMA_JOGADA = 4'd6,
    PROXIMA_RODADA = 4'd7,
    FIM_GANHOU     = 4'd8,
    FIM_PERDEU     = 4'd9,
    FIM_TIMEOUT    = 4'd10
  } estado_t;

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  // An all-zero state would lock the LFSR, so a zero seed becomes this.
  localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

  // One Fibonacci step: shift left, XOR of the tapped bits enters bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/jogo_memoria_param_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load and step enable.
module lfsr16
  import jogo_memoria_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  // Load has priority over stepping; a zero seed is replaced so the sequence never stalls.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (!reset) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == 16'h0000) ? LFSR_ZERO_SUB : seed;
    end else if (enable) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/jogo_memoria_param.sv
// Memory game: generates a pseudo-random LED sequence, shows it, then
// checks the player's button presses against it, round by round.
module jogo_memoria_param
  import jogo_memoria_pkg::*;
#(
  parameter int N_BOTOES    = 4,
  parameter int MAX_RODADAS = 16,
  parameter int T_LED       = 4,
  parameter int T_APAGADO   = 2,
  parameter int T_TIMEOUT   = 20
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               jogar,
  input  logic                               modo,
  input  logic [15:0]                        semente,
  input  logic [N_BOTOES-1:0]                botoes,
  output logic [N_BOTOES-1:0]                leds,
  output logic                               ganhou,
  output logic                               perdeu,
  output logic                               timeout,
  output logic                               pronto,
  output logic [$clog2(MAX_RODADAS+1)-1:0]   rodada,
  output logic [3:0]                         db_estado
);

  localparam int IDX_W = $clog2(N_BOTOES);
  localparam int RW    = $clog2(MAX_RODADAS + 1);
  localparam int MW    = (MAX_RODADAS > 1) ? $clog2(MAX_RODADAS) : 1;
  localparam int TMAX  = (T_LED > T_APAGADO) ? T_LED : T_APAGADO;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int OW    = $clog2(T_TIMEOUT + 1);

  estado_t             estado;
  logic [RW-1:0]       indice;
  logic [RW-1:0]       indice_nxt;
  logic [RW-1:0]       fill_idx;
  logic [TW-1:0]       timer;
  logic [OW-1:0]       tmo;
  logic [N_BOTOES-1:0] botoes_ant;
  logic [N_BOTOES-1:0] jogada;
  logic [IDX_W-1:0]    mem [MAX_RODADAS];
  logic [15:0]         lfsr_q;
  logic                lfsr_load;
  logic                lfsr_en;
  logic [IDX_W-1:0]    entry_new;
  logic [IDX_W-1:0]    first_entry;
  logic [IDX_W-1:0]    mem_cur;
  logic [IDX_W-1:0]    mem_nxt;
  logic                press;
  logic                em_fim;

  function automatic logic [N_BOTOES-1:0] onehot(input logic [IDX_W-1:0] e);
    onehot    = '0;
    onehot[e] = 1'b1;
  endfunction

  assign em_fim     = (estado == FIM_GANHOU) || (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
  assign lfsr_load  = jogar && ((estado == INICIAL) || em_fim);
  assign lfsr_en    = (estado == PREPARA);
  assign entry_new  = IDX_W'(32'(lfsr_q[IDX_W-1:0]) % 32'(N_BOTOES));
  assign indice_nxt = indice + RW'(1);
  assign mem_cur    = mem[indice[MW-1:0]];
  assign mem_nxt    = mem[indice_nxt[MW-1:0]];
  // Entry 0 is still being written when the fill finishes in a single cycle.
  assign first_entry = (fill_idx == '0) ? entry_new : mem[0];
  assign press       = (|botoes) && !(|botoes_ant);
  assign db_estado   = estado;

  lfsr16 u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .load   (lfsr_load),
    .enable (lfsr_en),
    .seed   (semente),
    .state  (lfsr_q)
  );

  // Sequence storage, filled one entry per cycle while preparing.
  always_ff @(posedge clock) begin
    // NOTE: no reset on the storage; every entry is rewritten in PREPARA before it is ever read.
    if (estado == PREPARA) mem[fill_idx[MW-1:0]] <= entry_new;
  end

  // Previous button sample, used to detect a fresh press edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) botoes_ant <= '0;
    else        botoes_ant <= botoes;
  end

  // Game controller with registered display, flags and round counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= INICIAL;
      indice   <= '0;
      fill_idx <= '0;
      timer    <= '0;
      tmo      <= '0;
      jogada   <= '0;
      leds     <= '0;
      ganhou   <= 1'b0;
      perdeu   <= 1'b0;
      timeout  <= 1'b0;
      pronto   <= 1'b0;
      rodada   <= '0;
    end else if (lfsr_load) begin
      estado   <= PREPARA;
      indice   <= '0;
      fill_idx <= '0;
      timer    <= '0;
      tmo      <= '0;
      jogada   <= '0;
      leds     <= '0;
      ganhou   <= 1'b0;
      perdeu   <= 1'b0;
      timeout  <= 1'b0;
      pronto   <= 1'b0;
      rodada   <= modo ? RW'(1) : RW'(MAX_RODADAS);
    end else begin
      case (estado)
        PREPARA: begin
          fill_idx <= fill_idx + RW'(1);
          if (fill_idx == RW'(MAX_RODADAS - 1)) begin
            estado <= MOSTRA_LED;
            indice <= '0;
            timer  <= '0;
            leds   <= onehot(first_entry);
          end
        end
        MOSTRA_LED: begin
          if (timer == TW'(T_LED - 1)) begin
            timer  <= '0;
            leds   <= '0;
            estado <= MOSTRA_APAGADO;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        MOSTRA_APAGADO: begin
          if (timer == TW'(T_APAGADO - 1)) begin
            timer <= '0;
            if (indice == rodada - RW'(1)) begin
              indice <= '0;
              tmo    <= '0;
              estado <= ESPERA;
            end else begin
              indice <= indice_nxt;
              leds   <= onehot(mem_nxt);
              estado <= MOSTRA_LED;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ESPERA: begin
          if (press) begin
            jogada <= botoes;
            estado <= COMPARA;
          end else if (tmo == OW'(T_TIMEOUT - 1)) begin
            estado  <= FIM_TIMEOUT;
            timeout <= 1'b1;
            pronto  <= 1'b1;
          end else begin
            tmo <= tmo + OW'(1);
          end
        end
        COMPARA: begin
          // The expected value is one-hot, so equality also rejects multi-button presses.
          if (jogada != onehot(mem_cur)) begin
            estado <= FIM_PERDEU;
            perdeu <= 1'b1;
            pronto <= 1'b1;
          end else begin
            estado <= PROXIMA_JOGADA;
          end
        end
        PROXIMA_JOGADA: begin
          if (indice < rodada - RW'(1)) begin
            indice <= indice_nxt;
            tmo    <= '0;
            estado <= ESPERA;
          end else begin
            estado <= PROXIMA_RODADA;
          end
        end
        PROXIMA_RODADA: begin
          if (rodada == RW'(MAX_RODADAS)) begin
            estado <= FIM_GANHOU;
            ganhou <= 1'b1;
            pronto <= 1'b1;
          end else begin
            rodada <= rodada + RW'(1);
            indice <= '0;
            timer  <= '0;
            leds   <= onehot(mem[0]);
            estado <= MOSTRA_LED;
          end
        end
        default: ; // INICIAL and FIM_* hold until a start request
      endcase
    end
  end

endmodule

// File: doc/jogo_memoria_param.md
JOGO_MEMORIA_PARAM -- requirements
Module: jogo_memoria_param

Interface
REQ-001 SHALL have parameter N_BOTOES, default 4, number of buttons/LEDs (2..8).
REQ-002 SHALL have parameter MAX_RODADAS, default 16, sequence depth (1..64).
REQ-003 SHALL have parameter T_LED, default 4, cycles an LED is shown.
REQ-004 SHALL have parameter T_APAGADO, default 2, dark cycles between LEDs.
REQ-005 SHALL have parameter T_TIMEOUT, default 20, cycles allowed per player press.
REQ-006 SHALL have port clock  input  1  single system clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-008 SHALL have port jogar  input  1  start/restart request, level, sampled each cycle.
REQ-009 SHALL have port modo  input  1  0 = full sequence once, 1 = incremental rounds.
REQ-010 SHALL have port semente  input  16  LFSR seed, latched on start.
REQ-011 SHALL have port botoes  input  N_BOTOES  player buttons, synchronous to clock.
REQ-012 SHALL have port leds  output  N_BOTOES  one-hot display.
REQ-013 SHALL have ports ganhou, perdeu, timeout, pronto  output  1 each  end-of-game flags.
REQ-014 SHALL have port rodada  output  clog2(MAX_RODADAS+1)  current round length.
REQ-015 SHALL have port db_estado  output  4  state encoding.

Function
REQ-016 SHALL implement states INICIAL, PREPARA, MOSTRA_LED, MOSTRA_APAGADO, ESPERA, COMPARA, PROXIMA_JOGADA, PROXIMA_RODADA, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT.
REQ-017 INICIAL -> PREPARA when jogar=1; any FIM_* state -> PREPARA when jogar=1 (restart without reset).
REQ-018 PREPARA SHALL latch semente (0x0000 replaced by 0x0001), clear all counters/flags, fill MAX_RODADAS entries, one per cycle, entry i = lfsr[clog2(N_BOTOES)-1:0] mod N_BOTOES, LFSR advanced after each entry.
REQ-019 LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, shifting left, feedback into bit 0.
REQ-020 rodada SHALL start at 1 in modo=1 and at MAX_RODADAS in modo=0.
REQ-021 Display: entries 0..rodada-1 each shown T_LED cycles in MOSTRA_LED (leds = 1<<entry), then T_APAGADO cycles in MOSTRA_APAGADO with leds=0; then ESPERA.
REQ-022 Press = botoes≠0 in cycle t with botoes=0 in cycle t-1; presses outside ESPERA are ignored.
REQ-023 In ESPERA the timeout counter runs; reaching T_TIMEOUT cycles without a press -> FIM_TIMEOUT.
REQ-024 COMPARA: press not one-hot, or not equal to expected one-hot -> FIM_PERDEU; match -> PROXIMA_JOGADA.
REQ-025 PROXIMA_JOGADA: index < rodada-1 -> increment index, clear timeout, ESPERA; else PROXIMA_RODADA.
REQ-026 PROXIMA_RODADA: rodada = MAX_RODADAS -> FIM_GANHOU; else rodada+1, index 0, back to MOSTRA_LED.
REQ-027 A new press SHALL require botoes to return to all-zero first.
REQ-028 pronto SHALL be 1 in every FIM_* state; exactly one of ganhou/perdeu/timeout SHALL be 1 with it; all drop on the cycle PREPARA is entered.
REQ-029 jogar during a game (non-INICIAL, non-FIM) SHALL be ignored.

Reset
REQ-030 reset=0 SHALL asynchronously force INICIAL, leds=0, all flags 0, rodada=0, counters/LFSR cleared; memory contents undefined.
REQ-031 Release SHALL take effect at the first rising clock edge with reset=1; reset mid-game abandons the game.

Structure
REQ-032 State encoding, LFSR tap constants and zero-seed substitute SHALL live in package jogo_memoria_pkg.
REQ-033 The LFSR SHALL be sub-module lfsr16 (load, enable, state out); timers and sequence storage stay in the top.

Verification
REQ-034 N=4, MAX=4, modo=1, semente=0x0001: first displayed LED = 4'b0010; correct presses per model for 4 rounds -> ganhou=1, pronto=1, rodada=4.
REQ-035 Same seed, first press 4'b1111 -> perdeu=1 within 3 cycles of press; then jogar pulse without reset -> PREPARA, flags cleared, game replays identical sequence.
REQ-036 No press for T_TIMEOUT=20 cycles in ESPERA -> timeout=1, pronto=1, perdeu=0.
REQ-037 modo=0, MAX=4: all 4 LEDs shown before first ESPERA; 4 correct presses -> ganhou.
REQ-038 Button held across two expected presses -> only one press registered; timeout follows.
REQ-039 reset=0 asserted mid-MOSTRA_LED -> leds=0, db_estado=INICIAL immediately, without waiting for a clock edge.
